// File: rtl/sram_shared.sv
// sram_shared: block-RAM responder for the shared-memory client bus.
// Round-robin grant, single-word writes, BURST-word reads.
module sram_shared #(
    parameter int AN    = 24,
    parameter int DN    = 16,
    parameter int IN    = 4,
    parameter int BURST = 8,
    parameter int MW    = 12
) (
    input  logic          clkSYS,
    input  logic          reset,
    input  logic [AN-1:0] arb_addr [IN],
    input  logic [DN-1:0] arb_data [IN],
    input  logic          arb_wr   [IN],
    input  logic [IN-1:0] arb_req,
    output logic [IN-1:0] arb_ack,
    output logic [DN-1:0] arb_data_out,
    output logic [IN-1:0] arb_valid,
    output logic          busy
);

    localparam int IW = (IN > 1) ? $clog2(IN) : 1;
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        READ = 2'd2
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [IW-1:0]   last;
    logic [IW-1:0]   g;
    logic [IW-1:0]   gnt;
    logic [AN-1:0]   addr_q;
    logic [DN-1:0]   data_q;
    logic            wr_q;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_d;
    logic            rd_en;
    logic            we;
    logic [MW-1:0]   rd_idx;
    logic            found;
    logic [IW-1:0]   cand;
    int              tmp;

    logic [DN-1:0]   mem [2**MW];

    // Round-robin pick: first requester after the last granted client.
    always_comb begin
        gnt   = last;
        found = 1'b0;
        cand  = '0;
        tmp   = 0;
        for (int i = 1; i <= IN; i++) begin
            tmp = int'(last) + i;
            if (tmp >= IN) tmp = tmp - IN;
            cand = IW'(tmp);
            if (!found && arb_req[cand]) begin
                gnt   = cand;
                found = 1'b1;
            end
        end
    end

    // State and burst counter registers.
    always_ff @(posedge clkSYS) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Latch the granted client's request when leaving IDLE.
    always_ff @(posedge clkSYS) begin
        if (reset) begin
            last   <= IW'(IN - 1);
            g      <= '0;
            addr_q <= '0;
            data_q <= '0;
            wr_q   <= 1'b0;
        end else if (state == IDLE && arb_req != '0) begin
            last   <= gnt;
            g      <= gnt;
            addr_q <= arb_addr[gnt];
            data_q <= arb_data[gnt];
            wr_q   <= arb_wr[gnt];
        end
    end

    // Next state, ack, RAM write enable and read issue.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        arb_ack = '0;
        we      = 1'b0;
        rd_en   = 1'b0;
        rd_idx  = addr_q[MW-1:0];
        unique case (state)
            IDLE: begin
                if (arb_req != '0) state_d = ACK;
            end
            ACK: begin
                arb_ack[g] = 1'b1;
                if (wr_q) begin
                    we      = 1'b1;
                    state_d = IDLE;
                end else begin
                    rd_en   = 1'b1;
                    cnt_d   = CW'(1);
                    state_d = (BURST == 1) ? IDLE : READ;
                end
            end
            READ: begin
                rd_en  = 1'b1;
                rd_idx = MW'(addr_q + AN'(cnt));
                cnt_d  = cnt + CW'(1);
                if (cnt == CW'(BURST - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM write port; contents are not reset.
    always_ff @(posedge clkSYS) begin
        if (we) mem[addr_q[MW-1:0]] <= data_q;
    end

    // One-cycle read return with per-client valid strobe.
    always_ff @(posedge clkSYS) begin
        if (reset) begin
            arb_data_out <= '0;
            arb_valid    <= '0;
        end else begin
            arb_valid <= rd_en ? (IN'(1) << g) : '0;
            if (rd_en) arb_data_out <= mem[rd_idx];
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sram_shared.sv
// tb_sram_shared: directed self-checking bench for sram_shared.
// Expected words come from a bench-side memory image of what was written.
module tb_sram_shared;

    logic        clkSYS;
    logic        reset;
    logic [23:0] arb_addr [4];
    logic [15:0] arb_data [4];
    logic        arb_wr   [4];
    logic [3:0]  arb_req;
    logic [3:0]  arb_ack;
    logic [15:0] arb_data_out;
    logic [3:0]  arb_valid;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] model [4096];
    bit          known [4096];

    sram_shared #(
        .AN(24), .DN(16), .IN(4), .BURST(8), .MW(12)
    ) dut (
        .clkSYS      (clkSYS),
        .reset       (reset),
        .arb_addr    (arb_addr),
        .arb_data    (arb_data),
        .arb_wr      (arb_wr),
        .arb_req     (arb_req),
        .arb_ack     (arb_ack),
        .arb_data_out(arb_data_out),
        .arb_valid   (arb_valid),
        .busy        (busy)
    );

    initial clkSYS = 1'b0;
    always #5 clkSYS = ~clkSYS;

    initial begin
        #2000000;
        $display("FAIL timeout tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkSYS);
        #1;
    endtask

    task automatic do_write(input int c, input logic [23:0] a,
                            input logic [15:0] d);
        logic [11:0] ix;
        arb_addr[c] = a;
        arb_data[c] = d;
        arb_wr[c]   = 1'b1;
        arb_req[c]  = 1'b1;
        tick();
        chk("wr_ack", arb_ack, 32'(1) << c);
        arb_req[c] = 1'b0;
        ix = a[11:0];
        model[ix] = d;
        known[ix] = 1'b1;
        tick();
        chk("wr_idle", {arb_ack, busy}, 32'h0);
    endtask

    task automatic do_read(input int c, input logic [23:0] a);
        logic [23:0] ra;
        logic [11:0] ix;
        arb_addr[c] = a;
        arb_wr[c]   = 1'b0;
        arb_req[c]  = 1'b1;
        tick();
        chk("rd_ack", arb_ack, 32'(1) << c);
        arb_req[c] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            ra = a + 24'(k);
            ix = ra[11:0];
            chk("rd_valid", arb_valid, 32'(1) << c);
            if (known[ix]) chk("rd_data", arb_data_out, model[ix]);
            chk("rd_busy", busy, (k == 7) ? 0 : 1);
        end
        tick();
        chk("rd_gap", arb_valid, 0);
    endtask

    initial begin
        int  order [5];
        logic [3:0] stray;
        logic [23:0] ra;
        logic [11:0] ix;
        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4096; i++) begin
            known[i] = 1'b0;
            model[i] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            arb_addr[i] = '0;
            arb_data[i] = '0;
            arb_wr[i]   = 1'b0;
        end
        arb_req = '0;
        reset   = 1'b1;
        tick();
        tick();
        chk("rst_out", {arb_ack, arb_valid, arb_data_out, busy}, 32'h0);
        reset = 1'b0;
        tick();

        // single write then read, client 2
        do_write(2, 24'h000010, 16'hA5A5);
        arb_addr[2] = 24'h000010;
        arb_wr[2]   = 1'b0;
        arb_req[2]  = 1'b1;
        tick();
        chk("sr_ack", arb_ack, 32'h4);
        arb_req[2] = 1'b0;
        tick();
        chk("sr_first", {arb_valid, arb_data_out}, {4'h4, 16'hA5A5});
        for (int k = 1; k < 8; k++) tick();
        tick();
        chk("sr_done", {arb_valid, busy}, 0);

        // burst order, client 0
        for (int i = 0; i < 8; i++)
            do_write(0, 24'h000020 + 24'(i), 16'h0100 + 16'(i));
        do_read(0, 24'h000020);

        // aliasing: 0x001000 lands on index 0
        for (int i = 0; i < 8; i++)
            do_write(1, 24'(i), 16'h5000 + 16'(i));
        do_write(1, 24'h001000, 16'h1234);
        arb_addr[1] = 24'h000000;
        arb_req[1]  = 1'b1;
        arb_wr[1]   = 1'b0;
        tick();
        arb_req[1] = 1'b0;
        tick();
        chk("alias", arb_data_out, 32'h1234);
        for (int k = 1; k < 8; k++) tick();
        tick();
        do_read(1, 24'h000000);

        // address wrap across top of 24-bit space
        for (int i = 0; i < 4; i++)
            do_write(3, 24'hFFFFFC + 24'(i), 16'h7000 + 16'(i));
        do_read(3, 24'hFFFFFC);

        // back-to-back writes, client 3
        arb_wr[3]   = 1'b1;
        arb_addr[3] = 24'h000040;
        arb_data[3] = 16'hC000;
        arb_req[3]  = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("tp_ack", {arb_ack, busy}, {4'h8, 1'b1});
            model[12'h040 + 12'(n)] = 16'hC000 + 16'(n);
            known[12'h040 + 12'(n)] = 1'b1;
            if (n < 3) begin
                arb_addr[3] = 24'h000041 + 24'(n);
                arb_data[3] = 16'hC001 + 16'(n);
            end else begin
                arb_req[3] = 1'b0;
            end
            tick();
            chk("tp_idle", {arb_ack, busy}, 0);
        end
        do_read(3, 24'h000040);

        // round-robin with all clients holding read requests
        arb_addr[0] = 24'h000020;
        arb_addr[1] = 24'hFFFFFC;
        arb_addr[2] = 24'h000020;
        arb_addr[3] = 24'h000000;
        for (int i = 0; i < 4; i++) arb_wr[i] = 1'b0;
        reset   = 1'b1;
        arb_req = 4'hF;
        tick();
        reset = 1'b0;
        for (int r = 0; r < 5; r++) begin
            for (int w = 0; w < 20; w++) begin
                tick();
                if (arb_ack != 0) break;
            end
            chk("rr_ack", arb_ack, 32'(1) << order[r]);
            if (r > 0) chk("rr_gap", arb_valid, 0);
            for (int k = 0; k < 8; k++) begin
                tick();
                ra = arb_addr[order[r]] + 24'(k);
                ix = ra[11:0];
                chk("rr_valid", arb_valid, 32'(1) << order[r]);
                if (known[ix]) chk("rr_data", arb_data_out, model[ix]);
            end
        end
        arb_req = '0;
        tick();
        chk("rr_end", busy, 0);

        // reset in the middle of a burst
        arb_addr[1] = 24'h000020;
        arb_req[1]  = 1'b1;
        tick();
        arb_req[1] = 1'b0;
        tick();
        tick();
        tick();
        chk("mb_pre", arb_valid, 32'h2);
        reset = 1'b1;
        tick();
        chk("mb_rst", {arb_ack, arb_valid, arb_data_out, busy}, 0);
        tick();
        tick();
        reset = 1'b0;
        stray = '0;
        for (int k = 0; k < 12; k++) begin
            tick();
            stray = stray | arb_valid | arb_ack;
        end
        chk("mb_stray", {stray, busy}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
